// File: rtl/stock_arbiter.sv
// Two-port round-robin arbiter and read-modify-write sequencer for the vending stock array.
// State | meaning: IDLE wait/grant | READ fetch and compute | UPDATE write back | SWEEP reload-all walk.
module stock_arbiter #(
    parameter int NUM_SLOTS = 20,
    parameter int MAX_STOCK = 10,
    parameter int CNT_W     = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 REQ_A,
    input  logic                 REQ_B,
    input  logic [1:0]           OP_A,
    input  logic [1:0]           OP_B,
    input  logic [4:0]           SLOT_A,
    input  logic [4:0]           SLOT_B,
    output logic                 GNT_A,
    output logic                 GNT_B,
    output logic                 DONE,
    output logic                 DONE_ID,
    output logic [CNT_W-1:0]     STOCK_OUT,
    output logic                 ERR,
    output logic                 BUSY,
    output logic [NUM_SLOTS-1:0] IN_STOCK
);
    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_STOCK);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_UPDATE, S_SWEEP} state_t;

    state_t           state;
    logic [CNT_W-1:0] stock [NUM_SLOTS];
    logic             prio_b;
    logic [PTR_W-1:0] sweep_ptr;
    logic             lat_id;
    logic [1:0]       lat_op;
    logic [4:0]       lat_slot;
    logic [CNT_W-1:0] hold_val;
    logic             hold_we;

    logic             win_b;
    logic [1:0]       sel_op;
    logic             slot_ok;
    logic [CNT_W-1:0] cur_val;
    logic [CNT_W-1:0] nxt_val;
    logic             nxt_we;
    logic             nxt_err;

    // prio_b set means B wins a tie; it is flipped toward the other port on every grant
    assign win_b  = REQ_B && (!REQ_A || prio_b);
    assign sel_op = win_b ? OP_B : OP_A;

    always_comb begin
        cur_val = '0;
        nxt_val = '0;
        nxt_we  = 1'b0;
        nxt_err = 1'b0;
        slot_ok = ({1'b0, lat_slot} < 6'(NUM_SLOTS));
        if (slot_ok) begin
            cur_val = stock[lat_slot];
        end
        if (!slot_ok) begin
            nxt_err = 1'b1;
        end else begin
            case (lat_op)
                2'b00: nxt_val = cur_val;
                2'b01: begin
                    if (cur_val != '0) begin
                        nxt_val = cur_val - CNT_W'(1);
                        nxt_we  = 1'b1;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
                default: begin
                    nxt_val = MAX_VAL;
                    nxt_we  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            prio_b    <= 1'b0;
            sweep_ptr <= '0;
            lat_id    <= 1'b0;
            lat_op    <= 2'b00;
            lat_slot  <= '0;
            hold_val  <= '0;
            hold_we   <= 1'b0;
            GNT_A     <= 1'b0;
            GNT_B     <= 1'b0;
            DONE      <= 1'b0;
            DONE_ID   <= 1'b0;
            STOCK_OUT <= '0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            IN_STOCK  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock[i] <= '0;
            end
        end else begin
            GNT_A <= 1'b0;
            GNT_B <= 1'b0;
            DONE  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ_A || REQ_B) begin
                        GNT_A     <= !win_b;
                        GNT_B     <= win_b;
                        prio_b    <= !win_b;
                        lat_id    <= win_b;
                        lat_op    <= sel_op;
                        lat_slot  <= win_b ? SLOT_B : SLOT_A;
                        sweep_ptr <= '0;
                        BUSY      <= 1'b1;
                        state     <= (sel_op == 2'b11) ? S_SWEEP : S_READ;
                    end
                end
                S_READ: begin
                    hold_val  <= nxt_val;
                    hold_we   <= nxt_we;
                    DONE      <= 1'b1;
                    DONE_ID   <= lat_id;
                    STOCK_OUT <= nxt_val;
                    ERR       <= nxt_err;
                    state     <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (hold_we) begin
                        stock[lat_slot]    <= hold_val;
                        IN_STOCK[lat_slot] <= (hold_val != '0);
                    end
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                S_SWEEP: begin
                    stock[sweep_ptr]    <= MAX_VAL;
                    IN_STOCK[sweep_ptr] <= (MAX_VAL != '0);
                    // DONE is registered, so it is raised one edge early to land on the last-slot cycle
                    if (sweep_ptr == PTR_W'(NUM_SLOTS - 2)) begin
                        DONE      <= 1'b1;
                        DONE_ID   <= lat_id;
                        STOCK_OUT <= MAX_VAL;
                        ERR       <= 1'b0;
                    end
                    if (sweep_ptr == PTR_W'(NUM_SLOTS - 1)) begin
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        sweep_ptr <= sweep_ptr + PTR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
